nanojeff_mem: RTL and testbench

Parametrised unified instruction/data memory for the NanoJeff core, replacing the fixed 256x8 bench memory.
- Two asynchronous read ports (instruction, data) and one synchronous write port from the core.
- A boot-loader state machine fills memory from a valid/ready byte stream, holding the core in reset until loading completes.
- Sits between the core and the top level or bench; also usable as on-chip RAM for synthesis.

---
 rtl/nanojeff_pkg.sv | 10 +
 rtl/nanojeff_if.sv | 31 +++
 rtl/nanojeff_boot_loader.sv | 62 ++++++
 rtl/nanojeff_mem.sv | 84 ++++++++
 tb/tb_nanojeff_mem.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/nanojeff_pkg.sv
// rtl/nanojeff_pkg.sv - shared defaults and loader state encoding for nanojeff_mem
package nanojeff_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/nanojeff_if.sv
// rtl/nanojeff_if.sv - core read/write ports and loader byte stream of nanojeff_mem
interface nanojeff_if
  import nanojeff_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              core_run;
  logic [ADDR_W:0]   ld_count;
  logic              led;

  modport master (
    output iaddr, daddr, wdata, wen, ld_valid, ld_data, ld_last,
    input  inst, rdata, ld_ready, core_run, ld_count, led
  );

  modport slave (
    input  iaddr, daddr, wdata, wen, ld_valid, ld_data, ld_last,
    output inst, rdata, ld_ready, core_run, ld_count, led
  );
endinterface

// File: rtl/nanojeff_boot_loader.sv
// rtl/nanojeff_boot_loader.sv - boot FSM filling memory from a valid/ready stream
module nanojeff_boot_loader
  import nanojeff_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_run,
  output logic [ADDR_W:0]   ld_count,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  localparam state_t RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W-1:0] ptr;

  // The pointer never wraps, so it is always the low bits of the word count.
  assign ptr     = ld_count[ADDR_W-1:0];
  assign wr_addr = ptr;
  assign wr_data = ld_data;

  // state and word counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RESET_STATE;
      ld_count <= '0;
    end else begin
      state    <= state_nxt;
      ld_count <= count_nxt;
    end
  end

  // next state, loader write strobe and handshake outputs
  always_comb begin
    state_nxt = state;
    count_nxt = ld_count;
    ld_ready  = 1'b0;
    core_run  = 1'b0;
    wr_en     = 1'b0;
    case (state)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          wr_en     = 1'b1;
          count_nxt = ld_count + {{ADDR_W{1'b0}}, 1'b1};
          if (ld_last || (ptr == {ADDR_W{1'b1}})) state_nxt = ST_RUN;
        end
      end
      default: core_run = 1'b1;
    endcase
  end
endmodule

// File: rtl/nanojeff_mem.sv
// rtl/nanojeff_mem.sv - unified NanoJeff memory with boot loader; optional NANOJEFF_MMIO_LED_EN
module nanojeff_mem
  import nanojeff_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit BOOT_LOAD = 1'b1,
  parameter int MMIO_ADDR = 2**ADDR_W-1
) (
  input logic       clk,
  input logic       reset,
  nanojeff_if.slave bus
);
  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] MMIO_A = MMIO_ADDR[ADDR_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_we;
  logic [ADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0] ld_wdata;
  logic              core_run;
  logic              mmio_hit;
  logic              core_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wval;
  logic              led_q;

  nanojeff_boot_loader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BOOT_LOAD(BOOT_LOAD)
  ) u_loader (
    .clk     (clk),
    .reset   (reset),
    .ld_valid(bus.ld_valid),
    .ld_data (bus.ld_data),
    .ld_last (bus.ld_last),
    .ld_ready(bus.ld_ready),
    .core_run(core_run),
    .ld_count(bus.ld_count),
    .wr_en   (ld_we),
    .wr_addr (ld_waddr),
    .wr_data (ld_wdata)
  );

`ifdef NANOJEFF_MMIO_LED_EN
  localparam bit MMIO_EN = 1'b1;

  // LED register takes bit 0 of core stores to the MMIO address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              led_q <= 1'b0;
    else if (core_run && bus.wen && mmio_hit) led_q <= bus.wdata[0];
  end
`else
  localparam bit MMIO_EN = 1'b0;
  assign led_q = 1'b0;
`endif

  assign mmio_hit = MMIO_EN && (bus.daddr == MMIO_A);
  assign core_we  = core_run && bus.wen && !mmio_hit;

  // loader owns the write port while loading; the core only once released
  always_comb begin
    we    = ld_we;
    waddr = ld_waddr;
    wval  = ld_wdata;
    if (!ld_we) begin
      we    = core_we;
      waddr = bus.daddr;
      wval  = bus.wdata;
    end
  end

  // array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wval;
  end

  assign bus.inst     = mem[bus.iaddr];
  assign bus.rdata    = mmio_hit ? {{(DATA_W-1){1'b0}}, led_q} : mem[bus.daddr];
  assign bus.core_run = core_run;
  assign bus.led      = led_q;
endmodule

// File: tb/tb_nanojeff_mem.sv
// tb/tb_nanojeff_mem.sv - randomized self-checking bench for nanojeff_mem
module tb_nanojeff_mem;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;
`ifdef NANOJEFF_MMIO_LED_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanojeff_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  nanojeff_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  nanojeff_mem #(.DATA_W(DW), .ADDR_W(AW), .BOOT_LOAD(1'b1), .MMIO_ADDR(255)) dut (
    .clk(clk), .reset(rst_n), .bus(bus));
  nanojeff_mem #(.DATA_W(DW), .ADDR_W(AW), .BOOT_LOAD(1'b0), .MMIO_ADDR(255)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0));

  int n_cmp = 0;
  int n_err = 0;

  // reference model: memory image plus loader progress
  logic [7:0] ref_mem [DEPTH];
  bit         m_run;
  int         m_count;
  bit         m_led;

  function automatic logic [7:0] exp_rd(logic [7:0] a);
    if (MMIO && a == 8'hFF) return {7'b0, m_led};
    return ref_mem[a];
  endfunction

  task automatic set_in(bit v, logic [7:0] d, bit last, bit we, logic [7:0] da, logic [7:0] wd);
    bus.ld_valid = v; bus.ld_data = d; bus.ld_last = last;
    bus.wen = we; bus.daddr = da; bus.wdata = wd; bus.iaddr = da;
  endtask

  // one rising edge; model applies the same rules to the inputs in force
  task automatic tick();
    @(posedge clk);
    if (!m_run) begin
      if (bus.ld_valid) begin
        ref_mem[m_count] = bus.ld_data;
        m_count++;
        if (bus.ld_last || m_count == DEPTH) m_run = 1'b1;
      end
    end else if (bus.wen) begin
      if (MMIO && bus.daddr == 8'hFF) m_led = bus.wdata[0];
      else ref_mem[bus.daddr] = bus.wdata;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; m_run = 1'b0; m_count = 0; m_led = 1'b0;
    #2;
    n_cmp++; if (bus.ld_count !== 9'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.ld_count); end
    n_cmp++; if (bus.core_run !== 1'b0) begin n_err++; $display("FAIL rst_core_run: got %b want 0", bus.core_run); end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready: got %b want 1", bus.ld_ready); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0);
    bus0.ld_valid = 0; bus0.ld_data = 0; bus0.ld_last = 0;
    bus0.wen = 0; bus0.daddr = 0; bus0.wdata = 0; bus0.iaddr = 0;
    pulse_reset();
    n_cmp++; if (bus.led !== 1'b0) begin n_err++; $display("FAIL rst_led: got %b want 0", bus.led); end
    n_cmp++; if (bus0.core_run !== 1'b1) begin n_err++; $display("FAIL boot0_core_run: got %b want 1", bus0.core_run); end
    n_cmp++; if (bus0.ld_ready !== 1'b0) begin n_err++; $display("FAIL boot0_ld_ready: got %b want 0", bus0.ld_ready); end
  endtask

  task automatic test_basic_load();
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_in(1, w[i], i == 2, 0, 0, 0);
      tick();
    end
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.core_run !== 1'b1) begin n_err++; $display("FAIL basic_core_run: got %b want 1", bus.core_run); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL basic_ld_ready: got %b want 0", bus.ld_ready); end
    n_cmp++; if (bus.ld_count !== 9'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.ld_count); end
    for (int i = 0; i < 3; i++) begin
      bus.daddr = 8'(i); #1;
      n_cmp++; if (bus.rdata !== w[i]) begin n_err++; $display("FAIL basic_mem[%0d]: got %h want %h", i, bus.rdata, w[i]); end
    end
  endtask

  task automatic test_toggle_valid();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); set_in(i % 2 == 0, 8'($urandom), i == 6, 0, 0, 0);
      tick();
    end
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.ld_count !== 9'(m_count)) begin n_err++; $display("FAIL toggle_count: got %0d want %0d", bus.ld_count, m_count); end
    n_cmp++; if (bus.core_run !== m_run) begin n_err++; $display("FAIL toggle_core_run: got %b want %b", bus.core_run, m_run); end
    for (int i = 0; i < 4; i++) begin
      bus.daddr = 8'(i); bus.iaddr = 8'(i); #1;
      n_cmp++; if (bus.rdata !== ref_mem[i]) begin n_err++; $display("FAIL toggle_rdata[%0d]: got %h want %h", i, bus.rdata, ref_mem[i]); end
      n_cmp++; if (bus.inst !== ref_mem[i]) begin n_err++; $display("FAIL toggle_inst[%0d]: got %h want %h", i, bus.inst, ref_mem[i]); end
    end
  endtask

  task automatic test_full_load();
    logic [7:0] first;
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); set_in(1, 8'($urandom), 0, 0, 0, 0);
      if (i == DEPTH - 1) begin
        n_cmp++; if (bus.core_run !== 1'b0) begin n_err++; $display("FAIL full_early_run: got %b want 0", bus.core_run); end
        n_cmp++; if (bus.ld_count !== 9'd255) begin n_err++; $display("FAIL full_count255: got %0d want 255", bus.ld_count); end
      end
      tick();
    end
    first = ref_mem[0];
    @(negedge clk); set_in(1, ~first, 1, 0, 0, 0);
    n_cmp++; if (bus.core_run !== 1'b1) begin n_err++; $display("FAIL full_core_run: got %b want 1", bus.core_run); end
    tick();
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (bus.ld_count !== 9'd256) begin n_err++; $display("FAIL full_count: got %0d want 256", bus.ld_count); end
    n_cmp++; if (bus.rdata !== first) begin n_err++; $display("FAIL full_nowrap: got %h want %h", bus.rdata, first); end
    for (int a = 0; a < DEPTH; a++) begin
      bus.iaddr = 8'(a); #1;
      n_cmp++; if (bus.inst !== ref_mem[a]) begin n_err++; $display("FAIL full_inst[%0d]: got %h want %h", a, bus.inst, ref_mem[a]); end
    end
  endtask

  task automatic test_run_write();
    logic [7:0] old, a, d;
    old = ref_mem[8'h10];
    @(negedge clk); set_in(0, 0, 0, 1, 8'h10, 8'hA5); #1;
    n_cmp++; if (bus.rdata !== old) begin n_err++; $display("FAIL run_same_cycle: got %h want %h", bus.rdata, old); end
    tick();
    @(negedge clk); bus.wen = 0; #1;
    n_cmp++; if (bus.rdata !== 8'hA5) begin n_err++; $display("FAIL run_rdata: got %h want a5", bus.rdata); end
    n_cmp++; if (bus.inst !== 8'hA5) begin n_err++; $display("FAIL run_inst: got %h want a5", bus.inst); end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      @(negedge clk); set_in(1, ~d, 1, 1, a, d);
      tick();
      n_cmp++; if (bus.rdata !== exp_rd(a)) begin n_err++; $display("FAIL rand_rdata[%h]: got %h want %h", a, bus.rdata, exp_rd(a)); end
      n_cmp++; if (bus.inst !== ref_mem[a]) begin n_err++; $display("FAIL rand_inst[%h]: got %h want %h", a, bus.inst, ref_mem[a]); end
    end
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mmio();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_in(0, 0, 0, 1, 8'hFF, (i == 0) ? 8'h01 : 8'h3C);
      tick();
      @(negedge clk); bus.wen = 0; #1;
      n_cmp++; if (bus.led !== m_led) begin n_err++; $display("FAIL mmio_led: got %b want %b", bus.led, m_led); end
      n_cmp++; if (bus.rdata !== exp_rd(8'hFF)) begin n_err++; $display("FAIL mmio_rdata: got %h want %h", bus.rdata, exp_rd(8'hFF)); end
      n_cmp++; if (bus.inst !== ref_mem[255]) begin n_err++; $display("FAIL mmio_array: got %h want %h", bus.inst, ref_mem[255]); end
    end
  endtask

  task automatic test_wen_in_load();
    pulse_reset();
    @(negedge clk); set_in(0, 0, 0, 1, 8'h10, ~ref_mem[8'h10]);
    tick(); tick();
    @(negedge clk); bus.wen = 0; #1;
    n_cmp++; if (bus.rdata !== ref_mem[8'h10]) begin n_err++; $display("FAIL load_wen: got %h want %h", bus.rdata, ref_mem[8'h10]); end
    n_cmp++; if (bus.ld_count !== 9'd0) begin n_err++; $display("FAIL load_wen_count: got %0d want 0", bus.ld_count); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); set_in(1, 8'($urandom), 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_in(1, 8'($urandom), i == 2, 0, 0, 0);
      tick();
    end
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.ld_count !== 9'd3) begin n_err++; $display("FAIL reload_count: got %0d want 3", bus.ld_count); end
    for (int i = 0; i < 3; i++) begin
      bus.daddr = 8'(i); #1;
      n_cmp++; if (bus.rdata !== ref_mem[i]) begin n_err++; $display("FAIL reload_mem[%0d]: got %h want %h", i, bus.rdata, ref_mem[i]); end
    end
  endtask

  task automatic test_single_word();
    pulse_reset();
    @(negedge clk); set_in(1, 8'($urandom), 1, 0, 0, 0);
    tick();
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (bus.ld_count !== 9'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.ld_count); end
    n_cmp++; if (bus.core_run !== 1'b1) begin n_err++; $display("FAIL single_run: got %b want 1", bus.core_run); end
    n_cmp++; if (bus.rdata !== ref_mem[0]) begin n_err++; $display("FAIL single_mem: got %h want %h", bus.rdata, ref_mem[0]); end
  endtask

  task automatic test_boot0();
    logic [7:0] d;
    d = 8'($urandom);
    @(negedge clk);
    bus0.ld_valid = 1; bus0.ld_data = ~d; bus0.ld_last = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (bus0.core_run !== 1'b1) begin n_err++; $display("FAIL boot0_run: got %b want 1", bus0.core_run); end
    n_cmp++; if (bus0.ld_count !== 9'd0) begin n_err++; $display("FAIL boot0_count: got %0d want 0", bus0.ld_count); end
    bus0.ld_valid = 0; bus0.wen = 1; bus0.daddr = 8'h20; bus0.wdata = d; bus0.iaddr = 8'h20;
    @(posedge clk); #1;
    @(negedge clk); bus0.wen = 0; #1;
    n_cmp++; if (bus0.rdata !== d) begin n_err++; $display("FAIL boot0_write: got %h want %h", bus0.rdata, d); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_toggle_valid();
    test_full_load();
    test_run_write();
    test_mmio();
    test_wen_in_load();
    test_reset_mid_load();
    test_single_word();
    test_boot0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
